pu_wtrace: RTL

Trace buffer on the processing unit's register write-back port. It consumes the pu's we/rwd pair and captures each written value into a FIFO. A host or testbench drains the FIFO through a valid/ready stream. Alongside the FIFO it keeps a write counter, a running peak value (the Collatz trajectory maximum) and overflow/drop bookkeeping.

---
 rtl/pu_wtrace.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pu_wtrace.sv
// Trace buffer on the pu register write-back port: captures written values into a
// registered-read FIFO, with write/drop counters, running peak and overflow tracking.
module pu_wtrace #(
    parameter int DW           = 32,
    parameter int DEPTH        = 16,
    parameter int CW           = 16,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [DW-1:0]            rwd,
    input  logic                     arm,
    input  logic                     clr,
    output logic                     o_valid,
    output logic [DW-1:0]            o_data,
    input  logic                     o_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CW-1:0]            wcnt,
    output logic [CW-1:0]            dcnt,
    output logic [DW-1:0]            peak,
    output logic                     ovf,
    output logic                     frozen
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [AW:0]     w_wptr_nx;
    logic [AW:0]     w_rptr_nx;
    logic [DW-1:0]   r_mem [DEPTH];
    logic            r_valid;
    logic [DW-1:0]   r_data;
    logic [AW:0]     r_count;
    logic [CW-1:0]   r_wcnt;
    logic [CW-1:0]   r_dcnt;
    logic [DW-1:0]   r_peak;
    logic            r_ovf;
    logic            r_frozen;

    logic            w_full;
    logic            w_pop;
    logic            w_cap;
    logic            w_push;
    logic            w_drop;
    logic [DW-1:0]   w_head_nx;

    assign w_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop  = r_valid & o_ready;
    assign w_cap  = (r_state == S_RUN) & we;
    // A pop in the same cycle frees the slot, so a capture on a full FIFO still lands.
    assign w_push = w_cap & (~w_full | w_pop);
    assign w_drop = w_cap & w_full & ~w_pop;

    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nx = r_state;
        w_wptr_nx  = r_wptr + (AW+1)'(w_push);
        w_rptr_nx  = r_rptr + (AW+1)'(w_pop);
        if (clr) begin
            w_state_nx = S_IDLE;
            w_wptr_nx  = '0;
            w_rptr_nx  = '0;
        end else begin
            case (r_state)
                S_IDLE: if (arm) w_state_nx = S_RUN;
                S_RUN: begin
                    if (STOP_ON_FULL != 0 && w_drop) w_state_nx = S_HOLD;
                    else if (!arm)                   w_state_nx = S_IDLE;
                end
                S_HOLD:  w_state_nx = S_HOLD;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // The value written this cycle is the new head only when it lands at the next read slot.
    always_comb begin
        w_head_nx = r_mem[w_rptr_nx[AW-1:0]];
        if (w_push && (r_wptr[AW-1:0] == w_rptr_nx[AW-1:0])) w_head_nx = rwd;
    end

    // NOTE: the storage array has no reset; only pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push && !clr) r_mem[r_wptr[AW-1:0]] <= rwd;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_count  <= '0;
            r_wcnt   <= '0;
            r_dcnt   <= '0;
            r_peak   <= '0;
            r_ovf    <= 1'b0;
            r_frozen <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_wptr   <= w_wptr_nx;
            r_rptr   <= w_rptr_nx;
            r_valid  <= (w_wptr_nx != w_rptr_nx);
            r_count  <= w_wptr_nx - w_rptr_nx;
            r_frozen <= (w_state_nx == S_HOLD);
            if (!clr && (w_wptr_nx != w_rptr_nx)) r_data <= w_head_nx;
            if (clr) begin
                r_wcnt <= '0;
                r_dcnt <= '0;
                r_peak <= '0;
                r_ovf  <= 1'b0;
            end else begin
                if (w_push) begin
                    if (r_wcnt != '1) r_wcnt <= r_wcnt + 1'b1;
                    if (rwd > r_peak) r_peak <= rwd;
                end
                if (w_drop) begin
                    if (r_dcnt != '1) r_dcnt <= r_dcnt + 1'b1;
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign count   = r_count;
    assign wcnt    = r_wcnt;
    assign dcnt    = r_dcnt;
    assign peak    = r_peak;
    assign ovf     = r_ovf;
    assign frozen  = r_frozen;

endmodule
